// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter and fixed-latency access sequencer for the single-ported
// backing memory shared by the instruction and data caches.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W  = 30,
  parameter int unsigned LATENCY = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [31:0]       i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  input  logic [3:0]        d_be,
  output logic              d_ack,
  output logic [31:0]       d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  input  logic [31:0]       mem_rdata
);

  localparam int unsigned CNT_W  = $clog2(LATENCY) + 1;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACCESS,
    ST_RESP
  } state_t;

  typedef enum logic {
    SIDE_I,
    SIDE_D
  } side_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  side_t               last_q, last_d;
  side_t               winner;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_d;
  logic [DATA_W-1:0]   wdata_d;
  logic [BE_W-1:0]     be_d;
  logic                mem_en_d, mem_we_d, i_ack_d, d_ack_d;

  // State, counter and all registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      last_q    <= SIDE_D;
      we_q      <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      i_ack     <= 1'b0;
      d_ack     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      we_q      <= we_d;
      mem_addr  <= addr_d;
      mem_wdata <= wdata_d;
      mem_be    <= be_d;
      mem_en    <= mem_en_d;
      mem_we    <= mem_we_d;
      i_ack     <= i_ack_d;
      d_ack     <= d_ack_d;
    end
  end

  // Next-state, grant selection and next output values
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    we_d    = we_q;
    addr_d  = mem_addr;
    wdata_d = mem_wdata;
    be_d    = mem_be;
    winner  = SIDE_I;

    case (state_q)
      ST_IDLE: begin
        if (i_req || d_req) begin
          if (i_req && d_req) begin
            winner = (last_q == SIDE_D) ? SIDE_I : SIDE_D;
          end else begin
            winner = i_req ? SIDE_I : SIDE_D;
          end
          last_d = winner;
          if (winner == SIDE_I) begin
            addr_d  = i_addr;
            we_d    = 1'b0;
            wdata_d = '0;
            be_d    = 4'hF;
          end else begin
            addr_d  = d_addr;
            we_d    = d_we;
            wdata_d = d_we ? d_wdata : '0;
            be_d    = d_we ? d_be : 4'hF;
          end
          cnt_d   = CNT_W'(LATENCY - 1);
          state_d = (LATENCY == 1) ? ST_ACCESS : ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    mem_en_d = (state_d == ST_ACCESS);
    mem_we_d = (state_d == ST_ACCESS) && we_d;
    i_ack_d  = (state_d == ST_RESP) && (last_d == SIDE_I);
    d_ack_d  = (state_d == ST_RESP) && (last_d == SIDE_D);
  end

  // Read data is the synchronous memory output, gated to the acknowledge cycle
  assign i_rdata = i_ack ? mem_rdata : '0;
  assign d_rdata = d_ack ? mem_rdata : '0;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter and access sequencer for the single-ported backing memory behind the instruction and data caches. It accepts refill and writeback requests from the instruction side (read-only) and the data side (read/write). It grants one request at a time in round-robin order and models a fixed multi-cycle memory latency before issuing a single-cycle synchronous access. It returns the result with a one-cycle acknowledge, and the caches use that acknowledge to release their pipeline stall.

## Interface
- ADDR_W, 30, word-address width on all address ports
- LATENCY, 4, memory busy cycles from grant to access strobe; legal range ≥1
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low
- i_req  in  1  instruction-side request; held until i_ack
- i_addr  in  ADDR_W  instruction word address; stable while i_req
- i_ack  out  1  one-cycle completion pulse to instruction side
- i_rdata  out  32  read data, valid only while i_ack=1
- d_req  in  1  data-side request; held until d_ack
- d_we  in  1  1=write, 0=read; stable while d_req
- d_addr  in  ADDR_W  data word address
- d_wdata  in  32  write data
- d_be  in  4  byte enables for writes
- d_ack  out  1  one-cycle completion pulse to data side
- d_rdata  out  32  read data, valid only while d_ack=1
- mem_en  out  1  memory access strobe, one cycle per transaction
- mem_we  out  1  memory write enable, only with mem_en
- mem_addr  out  ADDR_W  latched transaction address
- mem_wdata  out  32  latched write data
- mem_be  out  4  latched byte enables
- mem_rdata  in  32  synchronous-read memory output; valid the cycle after mem_en

## Operation
- The FSM has four states: IDLE, WAIT, ACCESS and RESP.
- **IDLE:**
  - If any request is present, select a winner and latch owner, address, we, wdata and be.
  - Load cnt with LATENCY-1, then go to WAIT. If LATENCY=1, go directly to ACCESS.
- **WAIT:** Decrement cnt. When cnt reaches 1 (the last WAIT cycle), go to ACCESS.
- **ACCESS:** Assert mem_en for one cycle. mem_we equals the latched we. Then go to RESP.
- **RESP:**
  - Assert ack to the owner. The owner's rdata is passed through from mem_rdata.
  - The other ack stays 0.
  - Next state is always IDLE.
- **Arbitration:**
  - A single requester wins immediately.
  - On a tie, the winner is the side not granted last. last_grant updates at every grant.
  - Reset sets last_grant = DATA, so the first tie after reset goes to instruction.
- **Instruction transactions** force mem_we=0, mem_be=4'hF and mem_wdata=0 when latched.
- **Data reads:** d_be and d_wdata are ignored, and mem_be=4'hF.
- **Request sampling:**
  - Requests are sampled only in IDLE. Request edges in WAIT, ACCESS and RESP have no effect.
  - A requester must drop req on the edge where it sees ack. A req still high in the following IDLE is treated as a new request.
- mem_addr, mem_wdata and mem_be hold their latched values between transactions. Only mem_en and mem_we are strobed.
- i_rdata and d_rdata are 0 whenever the corresponding ack is 0.
- cnt width is clog2(LATENCY)+1. It never wraps, because it is loaded only in IDLE.

## Timing
- Reset state:
  - State=IDLE, cnt=0, last_grant=DATA.
  - i_ack=0, d_ack=0, i_rdata=0, d_rdata=0.
  - mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_be=0.
- Request sampled in IDLE at cycle t:
  - WAIT in cycles t+1 … t+LATENCY-1.
  - mem_en in cycle t+LATENCY.
  - ack in cycle t+LATENCY+1.
  - IDLE in cycle t+LATENCY+2.
- Throughput is one transaction per LATENCY+2 cycles. There are no back-to-back grants.
- Reset asserted mid-transaction:
  - All outputs clear immediately (asynchronously) and the FSM returns to IDLE.
  - The in-flight transaction is dropped with no ack.
  - Any write is dropped unless mem_en had already been sampled by the memory.
  - The requester must re-issue after reset release.
- Reset release: the first possible grant is at the first rising edge with reset=1.
- Simultaneous i_req and d_req arriving while busy: both wait. In the next IDLE the tie rule applies.

## Test plan
- **Instruction read** (LATENCY=4, mem[0x10]=0x00000013): i_req with i_addr=0x10 at cycle t -> mem_en=1 and mem_we=0 at t+4; i_ack=1 with i_rdata=0x00000013 at t+5; d_ack stays 0.
- **Data write then read:** d_we=1, d_addr=0x20, d_wdata=0xDEADBEEF, d_be=4'b0011 -> mem_we=1 and mem_be=4'b0011 at t+4, d_ack at t+5. A following read of 0x20 -> d_rdata=0x0000BEEF (memory previously zeroed).
- **Tie after reset:** i_req and d_req both high at t -> i_ack at t+5, d_ack at t+11 (second grant at t+6).
- **Starvation check:** both requesters re-request immediately after every ack for 20 transactions -> grants strictly alternate and the ack counts differ by ≤1.
- **Reset during WAIT** (assert at t+2): mem_en and acks are 0 immediately. Reissue i_req after release -> normal completion 5 cycles after sampling.
- **LATENCY=1 build:** request at t -> mem_en at t+1, ack at t+2, next grant possible at t+3.
